// File: rtl/bocks_pkg.sv
// Shared Bocks definitions: upload FSM states, timeout fill byte, SDRAM byte-lane order.
package bocks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FETCH  = 2'd2,
        ST_RESP   = 2'd3
    } upload_state_e;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    // Byte 0 of a 16-bit SDRAM word lives in mem_data[7:0]
    localparam bit BYTE0_IN_LOW_LANE = 1'b1;

    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic odd);
        return ((odd ^ ~BYTE0_IN_LOW_LANE) != 1'b0) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/bocks_upload_reader.sv
// HPS ioctl upload reader: serves byte reads from SDRAM words through a one-word cache.
// Optional BOCKS_UPLOAD_CHECKSUM_EN adds a modulo-256 upload_sum of returned bytes.
module bocks_upload_reader
    import bocks_pkg::*;
#(
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [26:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-2:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic              rd_err
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
    ,
    output logic [7:0]        upload_sum
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned WA_W  = ADDR_W - 1;

    upload_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              wait_q, wait_d;
    logic              req_q, req_d;
    logic [WA_W-1:0]   maddr_q, maddr_d;
    logic              err_q, err_d;
    logic              cvld_q, cvld_d;
    logic [WA_W-1:0]   ctag_q, ctag_d;
    logic [15:0]       cdata_q, cdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              upload_prev_q, upload_prev_d;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic             upload_rise;
    logic [CNT_W-1:0] cnt_inc;
    logic [WA_W-1:0]  word_addr;

    if (ADDR_W < 27) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^ioctl_addr[26:ADDR_W];
    end

    assign upload_rise = ioctl_upload & ~upload_prev_q;
    assign word_addr   = addr_q[ADDR_W-1:1];
    // Saturating count of FETCH cycles; never wraps back to zero
    assign cnt_inc     = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        din_d         = din_q;
        wait_d        = wait_q;
        req_d         = req_q;
        maddr_d       = maddr_q;
        err_d         = err_q;
        cvld_d        = cvld_q;
        ctag_d        = ctag_q;
        cdata_d       = cdata_q;
        cnt_d         = cnt_q;
        upload_prev_d = ioctl_upload;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
        sum_d         = sum_q;
`endif

        if (upload_rise) begin
            cvld_d = 1'b0;
            err_d  = 1'b0;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
            sum_d  = 8'h00;
`endif
        end

        // Upload ended while busy: abandon the transfer; a late mem_ack finds us in IDLE
        if ((state_q != ST_IDLE) && !ioctl_upload) begin
            state_d = ST_IDLE;
            wait_d  = 1'b0;
            req_d   = 1'b0;
            cvld_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ioctl_rd && ioctl_upload) begin
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                        wait_d  = 1'b1;
                        state_d = ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cvld_q && (ctag_q == word_addr)) begin
                        din_d   = sel_byte(cdata_q, addr_q[0]);
                        state_d = ST_RESP;
                    end else begin
                        req_d   = 1'b1;
                        maddr_d = word_addr;
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        req_d   = 1'b0;
                        cdata_d = mem_data;
                        ctag_d  = word_addr;
                        cvld_d  = 1'b1;
                        din_d   = sel_byte(mem_data, addr_q[0]);
                        state_d = ST_RESP;
                    end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        req_d   = 1'b0;
                        din_d   = TIMEOUT_FILL;
                        err_d   = 1'b1;
                        cvld_d  = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RESP: begin
                    wait_d  = 1'b0;
                    state_d = ST_IDLE;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
                    sum_d   = sum_q + din_q;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            din_q         <= 8'h00;
            wait_q        <= 1'b0;
            req_q         <= 1'b0;
            maddr_q       <= '0;
            err_q         <= 1'b0;
            cvld_q        <= 1'b0;
            ctag_q        <= '0;
            cdata_q       <= 16'h0000;
            cnt_q         <= '0;
            upload_prev_q <= 1'b0;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
            sum_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            wait_q        <= wait_d;
            req_q         <= req_d;
            maddr_q       <= maddr_d;
            err_q         <= err_d;
            cvld_q        <= cvld_d;
            ctag_q        <= ctag_d;
            cdata_q       <= cdata_d;
            cnt_q         <= cnt_d;
            upload_prev_q <= upload_prev_d;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign mem_req    = req_q;
    assign mem_addr   = maddr_q;
    assign rd_err     = err_q;
`ifdef BOCKS_UPLOAD_CHECKSUM_EN
    assign upload_sum = sum_q;
`endif

endmodule

// File: doc/bocks_upload_reader.md
# bocks_upload_reader

Serves HPS ioctl upload (save-file) requests by reading bytes out of Bocks SDRAM. It is the reverse of the existing ioctl download path: hps_io requests byte addresses, and this block fetches 16-bit words from the SDRAM controller's read port. It returns the addressed byte on `ioctl_din` and throttles hps_io with `ioctl_wait`. It sits in `bocks_top` between hps_io's upload signals and a dedicated read port of the SDRAM controller, in the `clk_sys` domain.

## Interface
Parameters:
- `ADDR_W`, 24: width of the byte address forwarded to memory; `ioctl_addr[ADDR_W-1:0]` is used and higher bits are ignored.
- `TIMEOUT`, 255: maximum number of cycles to wait for `mem_ack` before aborting a fetch.

Ports:
- `clk_sys`  in  1  system clock; all logic is single-clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  high for the duration of an upload.
- `ioctl_rd`  in  1  one-cycle strobe requesting the byte at `ioctl_addr`.
- `ioctl_addr`  in  27  byte address of the request.
- `ioctl_din`  out  8  returned byte.
- `ioctl_wait`  out  1  high while the requested byte is not yet valid.
- `mem_req`  out  1  word read request, held until acknowledged.
- `mem_addr`  out  ADDR_W-1  word address (`ioctl_addr[ADDR_W-1:1]`).
- `mem_ack`  in  1  one-cycle pulse; `mem_data` is valid in the same cycle.
- `mem_data`  in  16  read word; byte 0 is in [7:0], byte 1 is in [15:8].
- `rd_err`  out  1  sticky flag: a fetch timed out during this upload.

## Operation
- Reset values:
  - `ioctl_din` = 0, `ioctl_wait` = 0, `mem_req` = 0, `mem_addr` = 0, `rd_err` = 0.
  - Word cache invalid; FSM in IDLE.
- FSM states: IDLE, LOOKUP, FETCH, RESP.
- IDLE:
  - On `ioctl_rd & ioctl_upload`, latch the address, set `ioctl_wait` = 1, go to LOOKUP.
  - `ioctl_rd` while `ioctl_upload` = 0 is ignored.
- LOOKUP:
  - On a cache hit (cache valid and word address equal), load `ioctl_din` from the cached byte selected by `addr[0]`, go to RESP.
  - On a miss, assert `mem_req` with `mem_addr`, clear the timeout counter, go to FETCH.
- FETCH:
  - On `mem_ack`: drop `mem_req`, store `mem_data` and the word address in the cache, mark it valid, load the selected byte into `ioctl_din`, go to RESP.
  - If the counter reaches TIMEOUT first: drop `mem_req`, set `ioctl_din` = 8'hFF, set `rd_err`, leave the cache invalid, go to RESP.
- RESP: clear `ioctl_wait`, go to IDLE.
- `ioctl_rd` arriving while the FSM is not in IDLE is a protocol violation. It is dropped with no state change.
- Rising edge of `ioctl_upload`: invalidate the cache and clear `rd_err`.
- Falling edge of `ioctl_upload` mid-fetch:
  - Abort: `mem_req` = 0, `ioctl_wait` = 0, back to IDLE, cache invalid.
  - A `mem_ack` arriving later is ignored.
- `ioctl_din` holds its last value between requests.

## Timing
- Request sampled at edge N:
  - `ioctl_wait` is 1 from N+1.
  - Hit: `ioctl_din` is valid at N+2 and `ioctl_wait` is 0 at N+3.
  - Miss: `mem_req` rises at N+2. If `mem_ack` arrives at edge M, `ioctl_din` is valid at M+1 and `ioctl_wait` is 0 at M+2.
- The timeout counter is `$clog2(TIMEOUT+1)` bits, counts FETCH cycles, and saturates; it never wraps.
- `mem_req` never deasserts before `mem_ack`, except on timeout or abort.
- Back-to-back requests are accepted one cycle after `ioctl_wait` falls.

## Configuration
- `BOCKS_UPLOAD_CHECKSUM_EN` defined:
  - Adds output `upload_sum [7:0]`, the modulo-256 sum of every byte returned in RESP, including 8'hFF on timeout.
  - Cleared on reset and on the rising edge of `ioctl_upload`.
  - Updated at the same edge `ioctl_wait` falls.
- Not defined: the `upload_sum` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `bocks_pkg` holds:
  - The upload FSM state enum.
  - The timeout fill byte 8'hFF.
  - The `mem_data` byte-lane convention constant.
- Single module, no sub-module: the FSM, the one-word cache, and the timeout counter are inline.

## Test plan
- Even then odd byte:
  - Stimulus: rd at 0x000010, then rd at 0x000011; memory word 0x0008 = 16'hBEEF.
  - Response: first read returns din = 8'hEF after one `mem_req`; second read returns 8'hBE with no `mem_req` (cache hit, `ioctl_wait` high for 2 cycles).
- Miss latency:
  - Stimulus: memory acks 5 cycles after request.
  - Response: `ioctl_wait` falls exactly at M+2; `mem_addr` = `ioctl_addr >> 1`.
- Timeout:
  - Stimulus: TIMEOUT = 8, memory never acks.
  - Response: din = 8'hFF, `rd_err` = 1, `mem_req` low after 8 FETCH cycles; the next upload start clears `rd_err`.
- Abort:
  - Stimulus: `ioctl_upload` drops during FETCH, then a late `mem_ack` arrives.
  - Response: `ioctl_wait` = 0 and `mem_req` = 0 next cycle; the cache is unchanged by the late ack.
- Reset mid-fetch:
  - Stimulus: `reset_n` pulses low during FETCH.
  - Response: all outputs return to their reset values asynchronously; a re-read of the same address issues a new `mem_req`.
- Checksum (macro on):
  - Stimulus: upload 4 bytes 01, 02, 03, FE.
  - Response: `upload_sum` = 8'h04.
